// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-key synchronizer, debouncer and press/release/long-press pulse generator
// Long-press detection is compiled in only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int DEB_CNT  = 999_999,
    parameter int LONG_CNT = 49_999_999
) (
    input  logic       sys_clk_50M,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long
);

    localparam int DW = (DEB_CNT < 1) ? 1 : $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_FILT,
        PRESSED,
        REL_FILT
    } state_t;

    // Synchronizer holds raw (active-low) key values, so reset to all-released.
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] ks;

    always_ff @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    assign ks = ~sync2_q;

    for (genvar i = 0; i < 4; i++) begin : g_key
        state_t        state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;

        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (ks[i]) begin
                        dcnt_d  = '0;
                        state_d = PRESS_FILT;
                    end
                end
                PRESS_FILT: begin
                    if (!ks[i]) begin
                        dcnt_d  = '0;
                        state_d = RELEASED;
                    end else if (dcnt_q == DEB_MAX) begin
                        dcnt_d  = '0;
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!ks[i]) begin
                        dcnt_d  = '0;
                        state_d = REL_FILT;
                    end
                end
                REL_FILT: begin
                    if (ks[i]) begin
                        dcnt_d  = '0;
                        state_d = PRESSED;
                    end else if (dcnt_q == DEB_MAX) begin
                        dcnt_d  = '0;
                        state_d = RELEASED;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                default: begin
                    dcnt_d  = '0;
                    state_d = RELEASED;
                end
            endcase
        end

        always_ff @(posedge sys_clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RELEASED;
                dcnt_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CNT + 2);
        localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT);
        localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_CNT + 1);

        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          long_q, long_d;

        // hcnt parks one past LONG_CNT so the equality pulse fires only once per hold.
        always_comb begin
            hcnt_d = hcnt_q;
            long_d = 1'b0;
            if (state_q == PRESS_FILT && state_d == PRESSED) begin
                hcnt_d = '0;
            end else if ((state_q == PRESSED || state_q == REL_FILT) && hcnt_q != HOLD_SAT) begin
                hcnt_d = hcnt_q + HW'(1);
                long_d = (hcnt_q == HOLD_MAX);
            end
        end

        always_ff @(posedge sys_clk_50M or negedge rst_n) begin
            if (!rst_n) begin
                hcnt_q <= '0;
                long_q <= 1'b0;
            end else begin
                hcnt_q <= hcnt_d;
                long_q <= long_d;
            end
        end

        assign key_long[i] = long_q;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce against a run-length reference model
module tb_key_debounce;

    localparam int DEB_CNT  = 15;
    localparam int LONG_CNT = 99;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_long;

    int checks;
    int errors;

    // Reference model: raw keys delayed two edges, level flips after DEB_CNT+2 disagreeing samples.
    logic [3:0] m_s1, m_s2;
    logic [3:0] e_level, e_press, e_rel, e_long;
    int         run[4];
    int         press_cyc[4];
    int         cyc;

    key_debounce #(
        .DEB_CNT (DEB_CNT),
        .LONG_CNT(LONG_CNT)
    ) dut (
        .sys_clk_50M(clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        e_level = '0;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int k = 0; k < 4; k++) begin
            run[k] = 0;
            press_cyc[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] ks;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        ks      = m_s2;
        m_s2    = m_s1;
        m_s1    = ~key;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int k = 0; k < 4; k++) begin
            if (LONG_EN && e_level[k] && (cyc - press_cyc[k] == LONG_CNT + 1))
                e_long[k] = 1'b1;
            if (ks[k] != e_level[k]) begin
                run[k]++;
                if (run[k] == DEB_CNT + 2) begin
                    run[k]     = 0;
                    e_level[k] = ks[k];
                    if (ks[k]) begin
                        e_press[k]   = 1'b1;
                        press_cyc[k] = cyc;
                    end else begin
                        e_rel[k] = 1'b1;
                    end
                end
            end else begin
                run[k] = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("level", key_level, e_level);
        chk("press", key_press, e_press);
        chk("release", key_release, e_rel);
        chk("long", key_long, e_long);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        key    = 4'hF;
        model_reset();

        // Reset held, then released with keys idle.
        @(negedge clk);
        ticks(3);
        chk("reset_level", key_level, 4'b0000);
        rst_n = 1'b1;
        ticks(50);
        chk("idle_level", key_level, 4'b0000);

        // Clean press and release on key 0.
        key[0] = 1'b0;
        ticks(18);
        chk("press0_early", key_press, 4'b0000);
        tick();
        chk("press0_edge", key_press, 4'b0001);
        chk("press0_level", key_level, 4'b0001);
        tick();
        chk("press0_one_cycle", key_press, 4'b0000);
        ticks(5);
        key[0] = 1'b1;
        ticks(18);
        chk("rel0_early", key_release, 4'b0000);
        tick();
        chk("rel0_edge", key_release, 4'b0001);
        chk("rel0_level", key_level, 4'b0000);
        ticks(10);

        // Bounce on key 1 must not qualify.
        key[1] = 1'b0; ticks(10);
        key[1] = 1'b1; ticks(3);
        key[1] = 1'b0; ticks(10);
        key[1] = 1'b1; ticks(30);
        chk("bounce_level", key_level, 4'b0000);
        key[1] = 1'b0;
        ticks(18);
        tick();
        chk("bounce_then_press", key_press, 4'b0010);
        key[1] = 1'b1;
        ticks(30);

        // Simultaneous press on all keys.
        key = 4'b0000;
        ticks(18);
        tick();
        chk("simul_press", key_press, 4'b1111);
        chk("simul_level", key_level, 4'b1111);
        key = 4'b1111;
        ticks(30);
        chk("simul_released", key_level, 4'b0000);

        // Long hold on key 2.
        key = 4'b1011;
        ticks(19);
        chk("long_press", key_press, 4'b0100);
        ticks(99);
        chk("long_early", key_long, 4'b0000);
        tick();
        chk("long_edge", key_long, LONG_EN ? 4'b0100 : 4'b0000);
        ticks(500);
        key = 4'b1111;
        ticks(30);

        // Reset during filtering, then during a hold, with key 3 held low throughout.
        key[3] = 1'b0;
        ticks(8);
        do_reset();
        chk("rst_filt_level", key_level, 4'b0000);
        ticks(3);
        rst_n = 1'b1;
        ticks(18);
        chk("rst_filt_early", key_press, 4'b0000);
        tick();
        chk("rst_filt_repress", key_press, 4'b1000);
        ticks(10);
        do_reset();
        chk("rst_hold_release", key_release, 4'b0000);
        chk("rst_hold_level", key_level, 4'b0000);
        ticks(2);
        rst_n = 1'b1;
        ticks(18);
        tick();
        chk("rst_hold_repress", key_press, 4'b1000);
        key[3] = 1'b1;
        ticks(30);

        // Randomized bursts of press, release and glitches across all keys.
        for (int it = 0; it < 80; it++) begin
            key = 4'($urandom);
            ticks($urandom_range(1, 40));
        end
        key = 4'b0110;
        ticks(150);
        key = 4'hF;
        ticks(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounced push-button input block for the four board keys, the input-side counterpart of the LED blinker. It samples four active-low mechanical keys on the 50 MHz system clock and synchronizes and debounces each one independently. It reports, per key, a stable pressed level plus single-cycle press, release and (optionally) long-press event pulses. Downstream LED and control logic consume these pulses directly.

## Interface
- `DEB_CNT`, default 999_999: debounce qualification length minus one. The raw change must persist DEB_CNT+1 cycles, which is 20 ms at 50 MHz.
- `LONG_CNT`, default 49_999_999: hold time minus one before a long-press event, which is 1 s at 50 MHz.
- `sys_clk_50M` input 1: system clock, 50 MHz, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key` input 4: raw keys, active-low (0 = pressed), asynchronous to clock.
- `key_level` output 4: debounced state, 1 = pressed. Registered.
- `key_press` output 4: one-cycle pulse on a debounced press. Registered.
- `key_release` output 4: one-cycle pulse on a debounced release. Registered.
- `key_long` output 4: one-cycle pulse when a press has been held LONG_CNT+1 cycles. Registered.

## Operation
- Per key, a 2-flop synchronizer produces `ks[i]`, which is 1 when the key is pressed.
- Per-key FSM states: `RELEASED`, `PRESS_FILT`, `PRESSED`, `REL_FILT`. Each key has a 20-bit filter counter `dcnt`.
  - `RELEASED`: if `ks`=1, clear `dcnt` and go to `PRESS_FILT`.
  - `PRESS_FILT`:
    - If `ks`=0 (bounce), clear `dcnt` and return to `RELEASED` with no event.
    - Else, if `dcnt`==DEB_CNT, go to `PRESSED`: set `key_level`=1, pulse `key_press`, clear `dcnt`.
    - Else increment `dcnt`.
  - `PRESSED`: if `ks`=0, clear `dcnt` and go to `REL_FILT`.
  - `REL_FILT`: mirror of `PRESS_FILT`.
    - `ks`=1 returns to `PRESSED` with no event.
    - `dcnt`==DEB_CNT goes to `RELEASED`: set `key_level`=0, pulse `key_release`.
- Long press (macro enabled only):
  - Per-key 26-bit `hcnt` clears on entry to `PRESSED` and increments while in `PRESSED` or `REL_FILT`.
  - When `hcnt`==LONG_CNT, pulse `key_long` once. `hcnt` then saturates, so there is no auto-repeat.
  - A bounce in `REL_FILT` that returns to `PRESSED` does not clear `hcnt`.
- Keys are fully independent. Simultaneous presses yield simultaneous pulses in the same cycle.
- Width rule: `dcnt` must hold DEB_CNT and `hcnt` must hold LONG_CNT. Compares are equality only. Counters never wrap.

## Timing
- Reset values:
  - Synchronizer flops are 1 (raw released).
  - All FSMs are in `RELEASED`.
  - `dcnt` and `hcnt` are 0.
  - `key_level`, `key_press`, `key_release` and `key_long` are all 4'b0.
- Press latency: if the raw key goes low and stays low from edge N, `key_press` and `key_level` rise at edge N+DEB_CNT+3. That is 2 synchronizer stages plus DEB_CNT+1 filter cycles.
- Release latency is identical and measured from the raw rising edge.
- The `key_long` edge is at press edge + LONG_CNT+1 cycles, counted from the cycle `key_press` asserts.
- Pulses last exactly one cycle. `key_press` and `key_release` never assert in the same cycle for the same key.
- A glitch shorter than DEB_CNT+1 synchronized cycles produces no event and no level change.
- Reset mid-filter or mid-hold aborts immediately with no event emitted.
- A key held low across reset deassertion is reported as a fresh press DEB_CNT+3 cycles later.

## Configuration
- `KEY_LONG_PRESS_EN` defined: the `hcnt` counters and `key_long` generation are compiled in.
- `KEY_LONG_PRESS_EN` undefined: no `hcnt` registers exist and `key_long` is tied to 4'b0. All other behaviour is unchanged.

## Test plan
All scenarios use DEB_CNT=15 and LONG_CNT=99.
- **Reset:** hold `rst_n`=0 with `key`=4'b1111 → all outputs 0. Release reset and wait 50 cycles → outputs stay 0.
- **Clean press:** drive `key[0]`=0 at edge N and hold → `key_press`=4'b0001 for exactly one cycle at edge N+18 and `key_level[0]`=1 from then on. Raise `key[0]` → one `key_release[0]` pulse 18 cycles later.
- **Bounce:** toggle `key[1]` low 10 cycles, high 3, low 10, then high → no pulses and `key_level` stays 0. Then hold low 16 or more synchronized cycles → exactly one `key_press[1]`.
- **Simultaneous:** drive `key`=4'b0000 at the same edge → `key_press`=4'b1111 in a single cycle and `key_level`=4'b1111.
- **Long press (macro on):** hold `key[2]` low → `key_long[2]` pulses once exactly 100 cycles after `key_press[2]`, with no second pulse after a further 500 cycles. With the macro off, `key_long` stays 0 throughout.
- **Reset mid-operation:** assert `rst_n`=0 during `PRESS_FILT` of `key[3]` and again while it is `PRESSED` → outputs clear immediately with no release pulse. With `key[3]` still low after reset, a press is reported 18 cycles after deassertion.
